// File: rtl/spi3w_pkg.sv
// Shared types and defaults for the three-wire SPI responder.
`timescale 1ns/1ps
package spi3w_pkg;

    localparam int ADDR_W_DEF      = 7;
    localparam int DATA_W_DEF      = 8;
    localparam int SYNC_STAGES_DEF = 2;

    // R/W bit value that selects a read frame
    localparam logic RW_READ = 1'b1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        WDATA   = 3'd2,
        RDATA   = 3'd3,
        WAIT_CS = 3'd4
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi3w_sync_edge.sv
// N-stage synchroniser for one asynchronous pin with registered rise/fall pulses.
// Edge pulses appear STAGES+1 CLK after the pin transition.
`timescale 1ns/1ps
module spi3w_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_r;
    logic              prev_r;
    logic              rise_r;
    logic              fall_r;

    // Shift the pin through the synchroniser chain; resets to the pin's idle level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_r <= {STAGES{RST_VAL}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    // Delayed copy of the synced level and single-cycle edge pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_r <= RST_VAL;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            prev_r <= sync_r[STAGES-1];
            rise_r <= sync_r[STAGES-1] & ~prev_r;
            fall_r <= ~sync_r[STAGES-1] & prev_r;
        end
    end

    assign level = sync_r[STAGES-1];
    assign rise  = rise_r;
    assign fall  = fall_r;

endmodule

// File: rtl/spi_three_wire_slave.sv
// Three-wire SPI responder: decodes R/W + address + data frames per SCEN-low
// window, strobes a register file and returns read data on the shared pad.
`timescale 1ns/1ps
module spi_three_wire_slave
    import spi3w_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              SCLK,
    input  logic              SCEN,
    input  logic              SDI,
    output logic              SDO,
    output logic              SDO_OE,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              wr_en,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rdata,
    output logic              frame_done
);

    // Shift register keeps all but the newest bit; the newest comes straight from sdi_s
    localparam int SH_W  = max_int(ADDR_W, DATA_W - 1);
    localparam int CNT_W = $clog2(max_int(1 + ADDR_W, DATA_W)) + 1;
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic              sclk_rise_s;
    logic              sclk_fall_s;
    logic              scen_s;
    logic              sdi_s;
    logic [4:0]        unused_sync_s;
    logic [ADDR_W:0]   cmd_s;
    logic [DATA_W-1:0] data_s;

    state_t            state_r;
    logic [SH_W-1:0]   shift_r;
    logic [CNT_W-1:0]  bitcnt_r;
    logic [DATA_W-1:0] tx_r;
    logic              rd_pend_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              wr_en_r;
    logic              rd_en_r;
    logic              frame_done_r;
    logic              sdo_r;
    logic              sdo_oe_r;

    spi3w_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
        .clk(CLK), .reset(reset), .d(SCLK),
        .level(unused_sync_s[0]), .rise(sclk_rise_s), .fall(sclk_fall_s)
    );

    spi3w_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_scen (
        .clk(CLK), .reset(reset), .d(SCEN),
        .level(scen_s), .rise(unused_sync_s[1]), .fall(unused_sync_s[2])
    );

    spi3w_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
        .clk(CLK), .reset(reset), .d(SDI),
        .level(sdi_s), .rise(unused_sync_s[3]), .fall(unused_sync_s[4])
    );

    assign cmd_s  = {shift_r[ADDR_W-1:0], sdi_s};
    assign data_s = {shift_r[DATA_W-2:0], sdi_s};

    // Frame FSM: command/data shifting, strobes, read-data serialisation and abort
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            shift_r      <= '0;
            bitcnt_r     <= '0;
            tx_r         <= '0;
            rd_pend_r    <= 1'b0;
            addr_r       <= '0;
            wdata_r      <= '0;
            wr_en_r      <= 1'b0;
            rd_en_r      <= 1'b0;
            frame_done_r <= 1'b0;
            sdo_r        <= 1'b0;
            sdo_oe_r     <= 1'b0;
        end else begin
            wr_en_r      <= 1'b0;
            rd_en_r      <= 1'b0;
            frame_done_r <= 1'b0;
            if (state_r != IDLE && scen_s) begin
                // SCEN released mid-frame: abandon without any strobe
                state_r   <= IDLE;
                bitcnt_r  <= '0;
                rd_pend_r <= 1'b0;
                sdo_r     <= 1'b0;
                sdo_oe_r  <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        sdo_r     <= 1'b0;
                        sdo_oe_r  <= 1'b0;
                        rd_pend_r <= 1'b0;
                        if (!scen_s) begin
                            bitcnt_r <= '0;
                            shift_r  <= '0;
                            state_r  <= CMD;
                        end
                    end
                    CMD: begin
                        if (sclk_rise_s) begin
                            shift_r <= {shift_r[SH_W-2:0], sdi_s};
                            if (bitcnt_r == CMD_LAST) begin
                                addr_r   <= cmd_s[ADDR_W-1:0];
                                bitcnt_r <= '0;
                                if (cmd_s[ADDR_W] == RW_READ) begin
                                    rd_en_r   <= 1'b1;
                                    rd_pend_r <= 1'b1;
                                    state_r   <= RDATA;
                                end else begin
                                    state_r <= WDATA;
                                end
                            end else begin
                                bitcnt_r <= bitcnt_r + CNT_ONE;
                            end
                        end
                    end
                    WDATA: begin
                        if (sclk_rise_s) begin
                            shift_r <= {shift_r[SH_W-2:0], sdi_s};
                            if (bitcnt_r == DATA_LAST) begin
                                wdata_r      <= data_s;
                                wr_en_r      <= 1'b1;
                                frame_done_r <= 1'b1;
                                bitcnt_r     <= '0;
                                state_r      <= WAIT_CS;
                            end else begin
                                bitcnt_r <= bitcnt_r + CNT_ONE;
                            end
                        end
                    end
                    RDATA: begin
                        // rdata is valid on the CLK after rd_en
                        if (rd_pend_r) begin
                            tx_r      <= rdata;
                            rd_pend_r <= 1'b0;
                        end else if (sclk_fall_s) begin
                            sdo_oe_r <= 1'b1;
                            sdo_r    <= tx_r[DATA_W-1];
                            tx_r     <= {tx_r[DATA_W-2:0], 1'b0};
                        end
                        if (sclk_rise_s) begin
                            if (bitcnt_r == DATA_LAST) begin
                                frame_done_r <= 1'b1;
                                bitcnt_r     <= '0;
                                state_r      <= WAIT_CS;
                            end else begin
                                bitcnt_r <= bitcnt_r + CNT_ONE;
                            end
                        end
                    end
                    WAIT_CS: begin
                        // Release the pad after the master has sampled the last bit
                        if (sclk_fall_s) begin
                            sdo_r    <= 1'b0;
                            sdo_oe_r <= 1'b0;
                        end
                    end
                    default: begin
                        state_r  <= IDLE;
                        sdo_r    <= 1'b0;
                        sdo_oe_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign SDO        = sdo_r;
    assign SDO_OE     = sdo_oe_r;
    assign addr       = addr_r;
    assign wdata      = wdata_r;
    assign wr_en      = wr_en_r;
    assign rd_en      = rd_en_r;
    assign frame_done = frame_done_r;

endmodule
